// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole design: UART character codes,
// game FSM codes and the TX scheduler state encoding.
package whack_pkg;

  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_H    = 8'h48;
  localparam logic [7:0] CH_ZERO = 8'h30;

  localparam logic [1:0] FSM_IDLE    = 2'd0;
  localparam logic [1:0] FSM_RUNNING = 2'd1;
  localparam logic [1:0] FSM_FINISH  = 2'd2;

  typedef enum logic [1:0] {
    SCHED_IDLE      = 2'd0,
    SCHED_WAIT_RISE = 2'd1,
    SCHED_WAIT_FALL = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_OVER = 2'd1,
    GRANT_HIT  = 2'd2,
    GRANT_MOLE = 2'd3
  } grant_t;

  function automatic logic [7:0] mole_char(input logic [2:0] idx);
    return CH_ZERO + {5'd0, idx};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_sat_counter.sv
// Up/down counter that holds at 0 and at MAX; simultaneous inc and dec cancel.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

  assign at_max = (count == MAX_VAL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Captures game events as pending requests and feeds them one byte at a time
// to uart_tx in fixed priority order (over > hit > mole).
module uart_tx_scheduler
  import whack_pkg::*;
#(
  parameter int HIT_DEPTH    = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         evt_over,
  input  logic         evt_hit,
  input  logic         evt_mole,
  input  logic [2:0]   mole_idx,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [2:0]   pending,
  output logic [7:0]   drop_count,
  output logic         sched_busy,
  output sched_state_t dbg_state
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  // Handshake with uart_tx: tx_start is a one-cycle request qualified by
  // tx_data; uart_tx acknowledges by raising tx_busy and signals completion by
  // dropping it. A start is only issued while tx_busy is low.
  sched_state_t  state;
  sched_state_t  state_next;
  grant_t        grant;
  logic [TW-1:0] timer;
  logic          over_flag;
  logic          mole_flag;
  logic [2:0]    mole_sel;
  logic [2:0]    hit_count;
  logic          hit_full;
  logic          drop_full;
  logic          mole_valid;
  logic          hit_grant;
  logic          drop_evt;

  assign mole_valid = evt_mole && (mole_idx <= 3'd4);
  assign hit_grant  = (grant == GRANT_HIT);
  assign drop_evt   = evt_hit && hit_full && !hit_grant && !flush;

  always_comb begin
    state_next = state;
    grant      = GRANT_NONE;
    unique case (state)
      SCHED_IDLE: begin
        if (!flush && !tx_busy) begin
          if (over_flag)               grant = GRANT_OVER;
          else if (hit_count != 3'd0)  grant = GRANT_HIT;
          else if (mole_flag)          grant = GRANT_MOLE;
          if (grant != GRANT_NONE) state_next = SCHED_WAIT_RISE;
        end
      end
      SCHED_WAIT_RISE: begin
        // No acknowledge within the window: the byte counts as sent.
        if (tx_busy)                              state_next = SCHED_WAIT_FALL;
        else if (timer == TW'(BUSY_TIMEOUT - 1))  state_next = SCHED_IDLE;
      end
      SCHED_WAIT_FALL: begin
        if (!tx_busy) state_next = SCHED_IDLE;
      end
      default: state_next = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= SCHED_IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      tx_start <= (grant != GRANT_NONE);
      if (state == SCHED_WAIT_RISE) timer <= timer + 1'b1;
      else                          timer <= '0;
      unique case (grant)
        GRANT_OVER: tx_data <= CH_R;
        GRANT_HIT:  tx_data <= CH_H;
        GRANT_MOLE: tx_data <= mole_char(mole_sel);
        default:    tx_data <= tx_data;
      endcase
    end
  end

  // Set wins over a same-cycle grant clear; flush wins over everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      over_flag <= 1'b0;
      mole_flag <= 1'b0;
      mole_sel  <= 3'd0;
    end else if (flush) begin
      over_flag <= 1'b0;
      mole_flag <= 1'b0;
    end else begin
      if (evt_over)                 over_flag <= 1'b1;
      else if (grant == GRANT_OVER) over_flag <= 1'b0;
      if (mole_valid) begin
        mole_flag <= 1'b1;
        mole_sel  <= mole_idx;
      end else if (grant == GRANT_MOLE) begin
        mole_flag <= 1'b0;
      end
    end
  end

  sat_counter #(.WIDTH(3), .MAX(HIT_DEPTH)) u_hit_q (
    .clock  (clock),
    .reset  (reset),
    .clear  (flush),
    .inc    (evt_hit),
    .dec    (hit_grant),
    .count  (hit_count),
    .at_max (hit_full)
  );

  sat_counter #(.WIDTH(8), .MAX(255)) u_drop_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (1'b0),
    .inc    (drop_evt && !drop_full),
    .dec    (1'b0),
    .count  (drop_count),
    .at_max (drop_full)
  );

  assign pending    = {over_flag, (hit_count != 3'd0), mole_flag};
  assign sched_busy = (state != SCHED_IDLE);
  assign dbg_state  = state;

endmodule
